// File: rtl/and_chain_array.sv
// and_chain_array: per-lane registered two-stage AND chain whose second
// stage is qualified by a saturating consecutive-cycle streak counter.
module and_chain_array #(
   parameter int NUM_CH = 5,
   parameter int HOLD   = 3,
   parameter int STICKY = 0,
   parameter int CNT_W  = $clog2(HOLD + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              clr,
   input  logic [NUM_CH-1:0] a,
   input  logic [NUM_CH-1:0] b,
   input  logic [NUM_CH-1:0] c,
   output logic [NUM_CH-1:0] d,
   output logic [NUM_CH-1:0] e,
   output logic [NUM_CH-1:0] f,
   output logic              f_all
);

   localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD);
   localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

   logic [NUM_CH-1:0] d_q, d_d;
   logic [NUM_CH-1:0] e_q, e_d;
   logic [NUM_CH-1:0] f_q, f_d;
   logic [CNT_W-1:0]  cnt_q [NUM_CH];
   logic [CNT_W-1:0]  cnt_d [NUM_CH];
   logic              f_all_q, f_all_d;
   logic [NUM_CH-1:0] hit;

   always_comb begin
      d_d     = d_q;
      e_d     = e_q;
      f_d     = f_q;
      hit     = '0;
      f_all_d = f_all_q;
      for (int i = 0; i < NUM_CH; i++) begin
         cnt_d[i] = cnt_q[i];
      end
      if (clr) begin
         d_d     = '0;
         e_d     = '0;
         f_d     = '0;
         f_all_d = 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = '0;
         end
      end else if (en) begin
         d_d = a & b;
         // e uses the registered d, not the fresh a&b
         e_d = d_q & c;
         for (int i = 0; i < NUM_CH; i++) begin
            if (!e_q[i]) begin
               cnt_d[i] = '0;
            end else if (cnt_q[i] == HOLD_C) begin
               cnt_d[i] = HOLD_C;
            end else begin
               cnt_d[i] = cnt_q[i] + ONE_C;
            end
            hit[i] = (cnt_d[i] == HOLD_C);
            if (STICKY != 0) begin
               f_d[i] = f_q[i] | hit[i];
            end else begin
               f_d[i] = hit[i];
            end
         end
         f_all_d = &f_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_q     <= '0;
         e_q     <= '0;
         f_q     <= '0;
         f_all_q <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         d_q     <= d_d;
         e_q     <= e_d;
         f_q     <= f_d;
         f_all_q <= f_all_d;
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign d     = d_q;
   assign e     = e_q;
   assign f     = f_q;
   assign f_all = f_all_q;

endmodule

// File: tb/tb_and_chain_array.sv
// Bench for and_chain_array: four builds (level/sticky HOLD=3, HOLD=1,
// HOLD=255) share stimulus and are checked against a streak-length model.
module tb_and_chain_array;

   localparam int N  = 5;
   localparam int NI = 4;
   localparam logic [N-1:0] ONES = '1;
   localparam logic [N-1:0] L2LO = 5'h1B;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic         en    = 1'b0;
   logic         clr   = 1'b0;
   logic [N-1:0] a = '0;
   logic [N-1:0] b = '0;
   logic [N-1:0] c = '0;

   logic [N-1:0] dq [NI];
   logic [N-1:0] eq [NI];
   logic [N-1:0] fq [NI];
   logic         faq [NI];

   int ncmp = 0;
   int nbad = 0;

   int hold_p   [NI] = '{3, 3, 1, 255};
   int sticky_p [NI] = '{0, 1, 0, 0};

   logic [N-1:0] md [NI];
   logic [N-1:0] me [NI];
   logic [N-1:0] mf [NI];
   logic         mfa [NI];
   int           run [NI][N];

   typedef struct {
      logic         en;
      logic         clr;
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic [N-1:0] c;
      logic [N-1:0] d;
      logic [N-1:0] e;
      logic [N-1:0] f;
      logic         fa;
   } vec_t;

   vec_t tv [12];

   always #5 clk = ~clk;

   and_chain_array #(.NUM_CH(N), .HOLD(3), .STICKY(0)) u_lvl (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
      .a(a), .b(b), .c(c),
      .d(dq[0]), .e(eq[0]), .f(fq[0]), .f_all(faq[0]));

   and_chain_array #(.NUM_CH(N), .HOLD(3), .STICKY(1)) u_stk (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
      .a(a), .b(b), .c(c),
      .d(dq[1]), .e(eq[1]), .f(fq[1]), .f_all(faq[1]));

   and_chain_array #(.NUM_CH(N), .HOLD(1), .STICKY(0)) u_h1 (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
      .a(a), .b(b), .c(c),
      .d(dq[2]), .e(eq[2]), .f(fq[2]), .f_all(faq[2]));

   and_chain_array #(.NUM_CH(N), .HOLD(255), .STICKY(0)) u_h255 (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
      .a(a), .b(b), .c(c),
      .d(dq[3]), .e(eq[3]), .f(fq[3]), .f_all(faq[3]));

   function automatic vec_t mk(input logic en_v, input logic clr_v,
                               input logic [N-1:0] av, input logic [N-1:0] bv,
                               input logic [N-1:0] cv, input logic [N-1:0] dv,
                               input logic [N-1:0] ev, input logic [N-1:0] fv,
                               input logic fav);
      vec_t v;
      v.en = en_v; v.clr = clr_v;
      v.a = av; v.b = bv; v.c = cv;
      v.d = dv; v.e = ev; v.f = fv; v.fa = fav;
      return v;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NI; k++) begin
         md[k] = '0; me[k] = '0; mf[k] = '0; mfa[k] = 1'b0;
         for (int i = 0; i < N; i++) run[k][i] = 0;
      end
   endtask

   // Streak length is tracked unbounded; f is "streak reached HOLD".
   task automatic model_edge();
      logic [N-1:0] ne;
      logic         hit;
      if (rst_n) begin
         for (int k = 0; k < NI; k++) begin
            if (clr) begin
               md[k] = '0; me[k] = '0; mf[k] = '0; mfa[k] = 1'b0;
               for (int i = 0; i < N; i++) run[k][i] = 0;
            end else if (en) begin
               ne = md[k] & c;
               md[k] = a & b;
               for (int i = 0; i < N; i++) begin
                  run[k][i] = me[k][i] ? run[k][i] + 1 : 0;
                  hit = (run[k][i] >= hold_p[k]);
                  mf[k][i] = (sticky_p[k] != 0) ? (mf[k][i] | hit) : hit;
               end
               me[k] = ne;
               mfa[k] = &mf[k];
            end
         end
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic chk_model(input string tag);
      for (int k = 0; k < NI; k++) begin
         chk($sformatf("%s u%0d d", tag, k), 32'(dq[k]), 32'(md[k]));
         chk($sformatf("%s u%0d e", tag, k), 32'(eq[k]), 32'(me[k]));
         chk($sformatf("%s u%0d f", tag, k), 32'(fq[k]), 32'(mf[k]));
         chk($sformatf("%s u%0d f_all", tag, k), 32'(faq[k]), 32'(mfa[k]));
      end
   endtask

   task automatic drv(input logic en_v, input logic clr_v,
                      input logic [N-1:0] av, input logic [N-1:0] bv,
                      input logic [N-1:0] cv);
      en = en_v; clr = clr_v; a = av; b = bv; c = cv;
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      chk_model(tag);
   endtask

   function automatic logic [N-1:0] rhi();
      return N'($urandom | $urandom | $urandom);
   endfunction

   initial begin
      tv[0]  = mk(1, 0, ONES, ONES, ONES, ONES, '0, '0, 0);
      tv[1]  = mk(1, 0, ONES, ONES, ONES, ONES, ONES, '0, 0);
      tv[2]  = mk(1, 0, ONES, ONES, ONES, ONES, ONES, '0, 0);
      tv[3]  = mk(1, 0, ONES, ONES, ONES, ONES, ONES, '0, 0);
      tv[4]  = mk(1, 0, ONES, ONES, ONES, ONES, ONES, ONES, 1);
      tv[5]  = mk(1, 0, ONES, ONES, L2LO, ONES, L2LO, ONES, 1);
      tv[6]  = mk(1, 0, ONES, ONES, ONES, ONES, ONES, L2LO, 0);
      tv[7]  = mk(1, 0, ONES, ONES, ONES, ONES, ONES, L2LO, 0);
      tv[8]  = mk(1, 0, ONES, ONES, ONES, ONES, ONES, L2LO, 0);
      tv[9]  = mk(1, 0, ONES, ONES, ONES, ONES, ONES, ONES, 1);
      tv[10] = mk(0, 0, '0, ONES, '0, ONES, ONES, ONES, 1);
      tv[11] = mk(0, 1, ONES, ONES, ONES, '0, '0, '0, 0);

      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_model("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // ramp, lane-2 streak break, stall hold, clear while stalled
      for (int v = 0; v < 12; v++) begin
         drv(tv[v].en, tv[v].clr, tv[v].a, tv[v].b, tv[v].c);
         step($sformatf("tv%0d", v));
         chk($sformatf("tv%0d d", v), 32'(dq[0]), 32'(tv[v].d));
         chk($sformatf("tv%0d e", v), 32'(eq[0]), 32'(tv[v].e));
         chk($sformatf("tv%0d f", v), 32'(fq[0]), 32'(tv[v].f));
         chk($sformatf("tv%0d f_all", v), 32'(faq[0]), 32'(tv[v].fa));
      end

      // stall with counter at 2
      drv(1, 0, ONES, ONES, ONES);
      repeat (4) step("pre_stall");
      for (int s = 0; s < 5; s++) begin
         drv(0, 0, N'($urandom), N'($urandom), N'($urandom));
         step("stall");
      end
      chk("stall f4 held", 32'(fq[0][4]), 32'(0));
      chk("stall e held", 32'(eq[0]), 32'(ONES));
      drv(1, 0, ONES, ONES, ONES);
      step("resume");
      chk("resume f4", 32'(fq[0][4]), 32'(1));

      // sticky lane 0 survives a broken streak, then clr
      drv(1, 0, ONES & ~N'(1), ONES, ONES);
      repeat (3) step("sticky");
      chk("level f0 drop", 32'(fq[0][0]), 32'(0));
      chk("sticky f0 keep", 32'(fq[1][0]), 32'(1));
      drv(1, 1, ONES, ONES, ONES);
      step("sticky_clr");
      chk("sticky clr f", 32'(fq[1]), 32'(0));

      // asynchronous reset mid-cycle with lanes active
      drv(1, 0, ONES, ONES, ONES);
      repeat (6) step("pre_rst");
      #3;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk_model("async_rst");
      chk("async f_all", 32'(faq[0]), 32'(0));
      drv(1, 1, ONES, ONES, ONES);
      step("rst_clr");
      chk("rst+clr noX", 32'($isunknown({dq[0], eq[0], fq[0], faq[0],
                                         dq[1], eq[1], fq[1], faq[1]})), 32'(0));
      rst_n = 1'b1;

      // long high run: HOLD=1 lag and HOLD=255 assertion edge
      drv(1, 0, ONES, ONES, ONES);
      for (int k = 0; k < 300; k++) begin
         step("long");
         if (k == 1)   chk("h1 f pre", 32'(fq[2]), 32'(0));
         if (k == 2)   chk("h1 f on", 32'(fq[2]), 32'(ONES));
         if (k == 255) chk("h255 f pre", 32'(fq[3]), 32'(0));
         if (k == 256) chk("h255 f on", 32'(fq[3]), 32'(ONES));
         if (k == 299) chk("h255 f stay", 32'(faq[3]), 32'(1));
      end

      // randomized traffic with occasional clr and async reset
      for (int k = 0; k < 1500; k++) begin
         drv($urandom_range(0, 9) != 0, $urandom_range(0, 59) == 0,
             rhi(), rhi(), rhi());
         step("rand");
         if ($urandom_range(0, 249) == 0) begin
            #2;
            rst_n = 1'b0;
            model_reset();
            #1;
            chk_model("rand_rst");
            step("rand_rst_hold");
            rst_n = 1'b1;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
      $finish;
   end

endmodule

// File: doc/and_chain_array.md
Name: and_chain_array

Overview:
- Parametrised multi-channel successor of the fixed 5-lane AND-chain benchmark block.
- Each lane registers a two-stage AND chain (d, e), then qualifies e with a consecutive-cycle streak counter to produce f. f is either level or sticky.
- Global stall enable, synchronous clear and an all-lanes summary output are added.
- Sits in the specification-mining benchmark designs as the configurable generator of AND-chain traces.

Parameters:
- NUM_CH, 5: number of independent lanes (1..32).
- HOLD, 3: consecutive cycles e must be high before f asserts (1..255).
- STICKY, 0: 0 = f is level (drops when the streak breaks); 1 = f latches until clr.
- CNT_W, $clog2(HOLD+1): streak counter width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  global advance; 0 freezes all state.
- clr  in  1  synchronous clear of d, e, counters and f (all lanes).
- a  in  NUM_CH  lane input a, bit i = lane i.
- b  in  NUM_CH  lane input b.
- c  in  NUM_CH  lane input c.
- d  out  NUM_CH  registered a&b.
- e  out  NUM_CH  registered d&c.
- f  out  NUM_CH  streak-qualified e.
- f_all  out  1  registered AND of all f bits.

Behaviour:
- Reset: rst_n low forces d, e, f, all counters and f_all to 0 immediately, independent of clk. Release is synchronous to the next rising edge.
- Priority at each edge: rst_n, then clr, then en. The per-lane statements below describe the edge when en=1 and clr=0.
  - d[i] <= a[i] & b[i]; latency 1 cycle.
  - e[i] <= d[i] & c[i]. This uses the registered d, so e reflects a&b from 2 edges ago and c from 1 edge ago.
  - Counter, if e[i]=1: cnt[i] <= cnt[i]+1, saturating at HOLD.
  - Counter, if e[i]=0: cnt[i] <= 0.
  - f[i] with STICKY=0: f[i] <= (next cnt[i] == HOLD).
  - f[i] with STICKY=1: f[i] <= f[i] | (next cnt[i] == HOLD).
  - f_all <= &(next f).
- Constant a=b=c=1 from before edge 0: d=1 after edge 0, e=1 after edge 1, cnt=1 after edge 2, f=1 after edge HOLD+1, f_all=1 after edge HOLD+1.
- en=0: every register holds its value and no inputs are sampled. A stall does not break a streak.
- clr=1: d, e, cnt, f and f_all go to 0 at the edge, regardless of en. Inputs sampled at that edge are discarded.
- Saturation: cnt never exceeds HOLD and never wraps. With level f and e held high, f stays 1 indefinitely.
- Streak break (STICKY=0): a single e=0 edge sets cnt to 0 and f to 0 at that same edge. Re-assertion needs HOLD fresh consecutive e-high edges.
- Sticky (STICKY=1): once f[i]=1, only clr or rst_n clears it. cnt still resets on e=0.
- HOLD=1: f follows e delayed by one edge.
- Reset mid-streak: all progress is lost. After release, full pipeline latency applies again.
- Lanes are fully independent; only f_all combines them.

Test Plan:
- Reset: rst_n=0 asserted mid-cycle with all lanes active -> d=e=f=0 and f_all=0 immediately, before the next edge. Release then a=b=c=all-ones with HOLD=3 -> d after edge 0, e after edge 1, f=all-ones after edge 4, f_all=1 after edge 4.
- Streak break, NUM_CH=5, HOLD=3, STICKY=0: lane 2 c=0 for one edge after f[2]=1 -> e[2]=0 next edge, then f[2]=0 and f_all=0 one edge later. f[2] returns 3 edges after e[2] is high again; other lanes stay 1 throughout.
- Sticky, STICKY=1: lane 0 reaches f[0]=1, then a[0]=0 -> f[0] stays 1 and cnt[0]=0. Pulse clr for one edge -> f[0]=0 after that edge.
- Stall: with cnt=2 on lane 4, en=0 for 5 cycles with a=b=c toggling -> d, e, cnt and f unchanged. en=1 with inputs high -> f[4]=1 after the first enabled edge.
- Saturation/HOLD=1: HOLD=1 build, e high for 300 cycles -> f tracks e with 1-edge lag and no wrap glitch. HOLD=255 build -> f asserts exactly 255 edges after e rises, with cnt stuck at 255.
- Clear vs enable: clr=1 and en=0 on the same edge -> all state cleared. clr=1 with rst_n=0 -> reset values and no X.
